instr_fetch: RTL

Instruction fetch sequencer sitting between the program counter and instruction memory. It reads the current PC, issues a held-request/ack read to instruction memory, buffers the returned word for decode behind a valid/ready handshake, and drives the PC load-enable and next-PC value back to the program counter. It is the consumer side of the PC interface. It also handles branch redirects, misalignment and bus-error faults.

---
 rtl/instr_fetch_pkg.sv | 16 +
 rtl/instr_fetch_timeout_ctr.sv | 31 +++
 rtl/instr_fetch.sv | 127 ++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared state encodings, fault codes and fetch constants
package instr_fetch_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_BUSERR   = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    localparam logic [31:0] RESET_PC  = 32'h0100_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;
endpackage

// File: rtl/instr_fetch_timeout_ctr.sv
// fetch_timeout_ctr: saturating cycle counter that flags an outstanding request as timed out (FETCH_TIMEOUT_EN builds only)
`ifdef FETCH_TIMEOUT_EN
module fetch_timeout_ctr
    import instr_fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count_q, count_d;

    // Count waiting cycles, holding at the limit so a held-off expiry still fires
    always_comb begin
        count_d = clear ? '0 : (enable && count_q != LIMIT) ? count_q + W'(1) : count_q;
        expired = enable && count_q == LIMIT;
    end

    // Counter register, active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) count_q <= '0;
        else count_q <= count_d;
    end
endmodule
`endif

// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven instruction fetch sequencer with redirect, squash and fault handling; FETCH_TIMEOUT_EN adds a request timeout
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        pc_en,
    output logic [31:0] pc_next,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        fault,
    output logic [1:0]  fault_cause
);
    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] ipc_q, ipc_d;
    logic [1:0]  cause_q, cause_d;
    logic        squash_q, squash_d;
    logic        go_req;
    logic [31:0] entry_addr;
    logic        tmo_expired;

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (go_req),
        .enable  (state_q == S_REQ && !imem_ack),
        .expired (tmo_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign tmo_expired = 1'b0;
`endif

    // Next-state logic: redirect overrides everything; a redirect that cannot withdraw an outstanding request squashes it instead
    always_comb begin
        entry_addr = redirect_valid ? redirect_pc : pc_in;
        state_d = state_q;
        addr_d = addr_q;
        data_d = data_q;
        ipc_d = ipc_q;
        cause_d = cause_q;
        squash_d = squash_q;
        pc_en = 1'b0;
        pc_next = redirect_pc;
        go_req = 1'b0;
        if (redirect_valid) begin
            pc_en = 1'b1;
            cause_d = FAULT_NONE;
            if (state_q == S_REQ && !imem_ack) begin
                squash_d = 1'b1;
            end else begin
                squash_d = 1'b0;
                go_req = 1'b1;
            end
        end else if (state_q == S_IDLE) begin
            go_req = 1'b1;
        end else if (state_q == S_REQ) begin
            if (imem_ack && squash_q) begin
                squash_d = 1'b0;
                go_req = 1'b1;
            end else if (imem_ack && imem_err) begin
                state_d = S_FAULT;
                cause_d = FAULT_BUSERR;
            end else if (imem_ack) begin
                data_d = imem_rdata;
                ipc_d = addr_q;
                pc_en = 1'b1;
                pc_next = addr_q + PC_INC;
                state_d = S_VALID;
            end else if (tmo_expired) begin
                state_d = S_FAULT;
                cause_d = FAULT_TIMEOUT;
                squash_d = 1'b0;
            end
        end else if (state_q == S_VALID && inst_ready) begin
            go_req = 1'b1;
        end
        if (go_req) begin
            state_d = (entry_addr[1:0] != 2'b00) ? S_FAULT : S_REQ;
            cause_d = (entry_addr[1:0] != 2'b00) ? FAULT_MISALIGN : FAULT_NONE;
            addr_d = entry_addr;
        end
    end

    // State and datapath registers, active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q <= RESET_PC;
            data_q <= NOP_INSTR;
            ipc_q <= '0;
            cause_q <= FAULT_NONE;
            squash_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            data_q <= data_d;
            ipc_q <= ipc_d;
            cause_q <= cause_d;
            squash_q <= squash_d;
        end
    end

    assign imem_req = state_q == S_REQ;
    assign imem_addr = addr_q;
    assign inst_valid = state_q == S_VALID;
    assign inst_data = data_q;
    assign inst_pc = ipc_q;
    assign fault = state_q == S_FAULT;
    assign fault_cause = cause_q;
endmodule
